// File: rtl/sm_decode8.sv
// Bit-serial two's-complement to sign-magnitude decoder for 8-bit words.
// One bit is converted per clock, LSB first, with valid/ready handshakes on both sides.
module sm_decode8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_sign,
   output logic [7:0] out_mag
);

   typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

   state_t     state_reg, state_next;
   logic [7:0] shift_reg, shift_next;
   logic [7:0] res_reg, res_next;
   logic [7:0] mag_reg, mag_next;
   logic       sign_reg, sign_next;
   logic       seen_one_reg, seen_one_next;
   logic       out_sign_reg, out_sign_next;
   logic [2:0] cnt_reg, cnt_next;
   logic       b;
   logic       m;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         shift_reg    <= 8'h00;
         res_reg      <= 8'h00;
         mag_reg      <= 8'h00;
         sign_reg     <= 1'b0;
         seen_one_reg <= 1'b0;
         out_sign_reg <= 1'b0;
         cnt_reg      <= 3'd0;
      end else begin
         state_reg    <= state_next;
         shift_reg    <= shift_next;
         res_reg      <= res_next;
         mag_reg      <= mag_next;
         sign_reg     <= sign_next;
         seen_one_reg <= seen_one_next;
         out_sign_reg <= out_sign_next;
         cnt_reg      <= cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      shift_next    = shift_reg;
      res_next      = res_reg;
      mag_next      = mag_reg;
      sign_next     = sign_reg;
      seen_one_next = seen_one_reg;
      out_sign_next = out_sign_reg;
      cnt_next      = cnt_reg;
      b             = shift_reg[0];
      // Negation serially: copy bits up to and including the first 1, invert the rest.
      m             = b ^ (sign_reg & seen_one_reg);
      in_ready      = (state_reg == IDLE);
      out_valid     = (state_reg == HOLD);

      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               shift_next    = in_data;
               sign_next     = in_data[7];
               seen_one_next = 1'b0;
               cnt_next      = 3'd0;
               state_next    = CONV;
            end
         end
         CONV: begin
            shift_next    = {1'b0, shift_reg[7:1]};
            res_next      = {m, res_reg[7:1]};
            seen_one_next = seen_one_reg | b;
            cnt_next      = cnt_reg + 3'd1;
            if (cnt_reg == 3'd7) begin
               mag_next      = {m, res_reg[7:1]};
               out_sign_next = sign_reg;
               state_next    = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign out_sign = out_sign_reg;
   assign out_mag  = mag_reg;

endmodule

// File: tb/tb_sm_decode8.sv
// Directed and randomized checks of the serial sign-magnitude decoder.
module tb_sm_decode8;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_sign;
   logic [7:0] out_mag;

   int n_cmp = 0;
   int n_bad = 0;

   sm_decode8 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sign  (out_sign),
      .out_mag   (out_mag)
   );

   always #5 clk = ~clk;

   // Presents one word in IDLE and waits (bounded) for out_valid; lat counts edges after accept.
   task automatic xfer(input logic [7:0] d, output int lat);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
      lat      = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      $display("xfer in=%h lat=%0d sign=%b mag=%h", d, lat, out_sign, out_mag);
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (out_sign !== 1'b0)  begin n_bad++; $display("FAIL reset_out_sign got %b want 0", out_sign); end
      n_cmp++; if (out_mag !== 8'h00)  begin n_bad++; $display("FAIL reset_out_mag got %h want 00", out_mag); end
   endtask

   // Table of words with hand-computed sign and magnitude, out_ready held high.
   task automatic test_table();
      logic [7:0] dv [8] = '{8'h05, 8'h00, 8'hFF, 8'hFB, 8'h80, 8'h81, 8'h7F, 8'h01};
      logic       es [8] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
      logic [7:0] em [8] = '{8'h05, 8'h00, 8'h01, 8'h05, 8'h80, 8'h7F, 8'h7F, 8'h01};
      int lat;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         xfer(dv[i], lat);
         n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL table_latency in=%h got %0d want 8", dv[i], lat); end
         n_cmp++; if (out_sign !== es[i]) begin n_bad++; $display("FAIL table_sign in=%h got %b want %b", dv[i], out_sign, es[i]); end
         n_cmp++; if (out_mag !== em[i]) begin n_bad++; $display("FAIL table_mag in=%h got %h want %h", dv[i], out_mag, em[i]); end
         n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL table_ready_in_hold in=%h got %b want 0", dv[i], in_ready); end
         @(negedge clk);
         n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL table_ready_after_h in=%h got %b want 1", dv[i], in_ready); end
         n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL table_valid_after_h in=%h got %b want 0", dv[i], out_valid); end
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hF0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         in_data = 8'(i * 37 + 3);
         n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_conv cyc=%0d got %b want 0", i, in_ready); end
         @(negedge clk);
      end
      for (int i = 0; i < 5; i++) begin
         in_data = 8'(i * 91 + 5);
         n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid cyc=%0d got %b want 1", i, out_valid); end
         n_cmp++; if (out_sign !== 1'b1)  begin n_bad++; $display("FAIL bp_sign cyc=%0d got %b want 1", i, out_sign); end
         n_cmp++; if (out_mag !== 8'h10)  begin n_bad++; $display("FAIL bp_mag cyc=%0d got %h want 10", i, out_mag); end
         n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL bp_ready_hold cyc=%0d got %b want 0", i, in_ready); end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      $display("backpressure released sign=%b mag=%h in_ready=%b", out_sign, out_mag, in_ready);
      n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL bp_ready_after_h got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_valid_after_h got %b want 0", out_valid); end
      n_cmp++; if (out_mag !== 8'h10)  begin n_bad++; $display("FAIL bp_mag_held_idle got %h want 10", out_mag); end
   endtask

   task automatic test_reset_mid();
      int lat;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h9C;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      $display("reset mid-conv in_ready=%b out_valid=%b sign=%b mag=%h", in_ready, out_valid, out_sign, out_mag);
      n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
      n_cmp++; if (out_sign !== 1'b0)  begin n_bad++; $display("FAIL rmid_out_sign got %b want 0", out_sign); end
      n_cmp++; if (out_mag !== 8'h00)  begin n_bad++; $display("FAIL rmid_out_mag got %h want 00", out_mag); end
      repeat (6) @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_discarded got %b want 0", out_valid); end
      xfer(8'h9C, lat);
      n_cmp++; if (lat !== 8)          begin n_bad++; $display("FAIL rmid_latency got %0d want 8", lat); end
      n_cmp++; if (out_sign !== 1'b1)  begin n_bad++; $display("FAIL rmid_sign_9c got %b want 1", out_sign); end
      n_cmp++; if (out_mag !== 8'h64)  begin n_bad++; $display("FAIL rmid_mag_9c got %h want 64", out_mag); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q [$];
      logic [7:0] d;
      logic [7:0] exp_mag;
      int cyc = 0;
      int last_acc = -1;
      int sent = 0;
      int got = 0;
      while (got < 200 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         n_cmp++; if (in_ready === 1'b1 && out_valid === 1'b1) begin n_bad++; $display("FAIL b2b_ready_valid_overlap cyc=%0d got 1 want 0", cyc); end
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         if (in_valid && in_ready) begin
            if (last_acc >= 0) begin
               n_cmp++; if (cyc - last_acc < 10) begin n_bad++; $display("FAIL b2b_spacing cyc=%0d got %0d want >=10", cyc, cyc - last_acc); end
            end
            last_acc = cyc;
            exp_q.push_back(in_data);
            sent++;
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL b2b_unexpected_result got sign=%b mag=%h want none", out_sign, out_mag);
            end else begin
               d       = exp_q.pop_front();
               exp_mag = d[7] ? (8'h00 - d) : d;
               $display("b2b word %0d in=%h sign=%b mag=%h", got, d, out_sign, out_mag);
               if (out_sign !== d[7]) begin n_bad++; $display("FAIL b2b_sign in=%h got %b want %b", d, out_sign, d[7]); end
               n_cmp++;
               if (out_mag !== exp_mag) begin n_bad++; $display("FAIL b2b_mag in=%h got %h want %h", d, out_mag, exp_mag); end
            end
            got++;
         end
      end
      in_valid = 1'b0;
      n_cmp++; if (got !== 200)        begin n_bad++; $display("FAIL b2b_received got %0d want 200", got); end
      n_cmp++; if (sent !== 200)       begin n_bad++; $display("FAIL b2b_sent got %0d want 200", sent); end
      n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL b2b_leftover got %0d want 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_table();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
